// File: rtl/y_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : y_mux_rr_if
// Brief    : Channel-side and output-side handshake bundle for y_mux_rr.
// Revision : 1.0 - initial release
// ============================================================================
interface y_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      mode;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_ch;
    logic                      out_ready;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/y_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : y_mux_rr
// Brief    : N-channel to 1 registered mux, fixed-priority or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module y_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    y_mux_rr_if.slave   bus
);
    localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_ch;
    logic [SELW-1:0]  r_ptr;

    logic                w_load;
    logic                w_any;
    logic                w_xfer;
    logic                w_hit;
    logic [SELW-1:0]     w_idx;
    logic [SELW-1:0]     w_gnt;
    logic [SELW-1:0]     w_ptr_nxt;
    logic [WIDTH-1:0]    w_data;
    logic [CHANNELS-1:0] w_ready;

    assign w_load = !r_valid | bus.out_ready;
    assign w_any  = |bus.in_valid;
    assign w_xfer = w_load & w_any & !reset;

    // Search order starts at r_ptr in round-robin mode, at 0 in fixed mode.
    always_comb begin
        w_gnt = '0;
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = bus.mode ? SELW'((int'(r_ptr) + k) % CHANNELS) : SELW'(k);
            if (!w_hit && bus.in_valid[w_idx]) begin
                w_hit = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (SELW'(c) == w_gnt) begin
                w_data = bus.in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt == SELW'(CHANNELS - 1)) ? '0 : w_gnt + SELW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_ch    <= w_gnt;
                r_ptr   <= w_ptr_nxt;
            end else begin
                // Drained with nothing to replace it: data/channel keep last value.
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
endmodule
`default_nettype wire

// File: tb/tb_y_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_mux_rr
// Brief    : Directed bench for y_mux_rr with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_mux_rr;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

    y_mux_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    y_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference arbitration: walk the channels in the order the mode dictates.
    function automatic int model_grant(input logic [3:0] v, input logic m, input int ptr);
        int idx;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = m ? (ptr + k) % CHANNELS : k;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    logic       m_live = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    always @(negedge clk) begin
        logic       load;
        int         g;
        logic [3:0] exp_rdy;
        load = !m_valid || bus.out_ready;
        g    = model_grant(bus.in_valid, bus.mode, m_ptr);
        exp_rdy = 4'b0000;
        if (!reset && load && g >= 0) exp_rdy[g] = 1'b1;
        if (m_live) begin
            chk("model out_valid", {63'd0, bus.out_valid}, {63'd0, m_valid});
            chk("model out_data", {56'd0, bus.out_data}, {56'd0, m_data});
            chk("model out_ch", {62'd0, bus.out_ch}, 64'(m_ch));
            chk("model in_ready", {60'd0, bus.in_ready}, {60'd0, exp_rdy});
            chk("onehot in_ready", 64'($countones(bus.in_ready) <= 1), 64'd1);
        end
        if (reset) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (m_live && load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*WIDTH +: WIDTH];
                m_ch    = g;
                m_ptr   = (g + 1) % CHANNELS;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};

        reset         = 1'b1;
        bus.mode      = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset out_data", {56'd0, bus.out_data}, 64'h00);
        chk("reset out_ch", {62'd0, bus.out_ch}, 64'd0);
        chk("reset in_ready", {60'd0, bus.in_ready}, 64'b0000);
        tick();

        // Fixed priority starves ch3 while ch1 stays valid.
        bus.mode      = 1'b0;
        bus.in_valid  = 4'b1010;
        bus.in_data   = pack(8'h00, 8'h11, 8'h00, 8'h33);
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("fixed out_ch", {62'd0, bus.out_ch}, 64'd1);
            chk("fixed out_data", {56'd0, bus.out_data}, 64'h11);
            chk("fixed in_ready", {60'd0, bus.in_ready}, 64'b0010);
            tick();
        end
        bus.in_valid = 4'b0000;
        tick();

        // Round-robin over four busy channels, no bubbles.
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = pack(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("rr out_ch", {62'd0, bus.out_ch}, 64'(seq[i]));
            chk("rr out_data", {56'd0, bus.out_data}, 64'(8'hA0 + seq[i]));
        end
        bus.in_valid = 4'b0000;
        tick();

        // Backpressure holds the registered ch2 word.
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b0100;
        bus.in_data   = pack(8'h00, 8'h00, 8'hA5, 8'h00);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 4'b0001;
        bus.in_data  = pack(8'h5A, 8'h00, 8'hEE, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall out_data", {56'd0, bus.out_data}, 64'hA5);
            chk("stall out_ch", {62'd0, bus.out_ch}, 64'd2);
            chk("stall in_ready", {60'd0, bus.in_ready}, 64'b0000);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", {60'd0, bus.in_ready}, 64'b0001);
        tick();
        chk("release out_data", {56'd0, bus.out_data}, 64'h5A);
        chk("release out_ch", {62'd0, bus.out_ch}, 64'd0);

        // Mid-stream reset with pointer at 3 must restart arbitration at ch0.
        bus.in_valid = 4'b0100;
        bus.in_data  = pack(8'h00, 8'h00, 8'hC2, 8'h00);
        tick();
        chk("pre-reset out_ch", {62'd0, bus.out_ch}, 64'd2);
        reset        = 1'b1;
        bus.in_valid = 4'b1001;
        bus.in_data  = pack(8'hD0, 8'h00, 8'h00, 8'hD3);
        @(negedge clk);
        chk("in-reset in_ready", {60'd0, bus.in_ready}, 64'b0000);
        tick();
        chk("post-reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", {60'd0, bus.in_ready}, 64'b0001);
        tick();
        chk("post-reset out_ch", {62'd0, bus.out_ch}, 64'd0);
        chk("post-reset out_data", {56'd0, bus.out_data}, 64'hD0);

        // Sweep every request pattern in both modes with mixed backpressure.
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 16; v++) begin
                bus.mode      = m[0];
                bus.in_valid  = v[3:0];
                bus.in_data   = pack(8'(v), 8'(v + 16), 8'(v + 32), 8'(v + 48));
                bus.out_ready = ~(v[0] & v[2]);
                tick();
            end
        end

        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/y_mux_rr.md
Y_MUX_RR -- requirements
Module: y_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel; legal range 1-64.
REQ-002 Parameter CHANNELS, default 4, number of input channels; legal range 1-16.
REQ-003 Parameter SELW, derived as max(1, clog2(CHANNELS)); width of channel index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-006 mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 in_valid  input  CHANNELS  bit i high = channel i offers a word.
REQ-008 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  CHANNELS  bit i high = channel i word accepted this cycle.
REQ-010 out_valid  output  1  out_data/out_ch hold a word.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_ch  output  SELW  index of channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accepts word when out_valid and out_ready are both high.

Function
REQ-014 load = !out_valid | out_ready; the output register accepts a new word only when load is high.
REQ-015 Grant g is computed combinationally each cycle from in_valid, mode and rr_ptr; no grant when in_valid == 0.
REQ-016 mode 0: g = lowest index i with in_valid[i] high; rr_ptr is ignored for selection.
REQ-017 mode 1: g = first index i with in_valid[i] high, searching rr_ptr, rr_ptr+1, ... with wrap modulo CHANNELS.
REQ-018 in_ready[g] = load & |in_valid; every other in_ready bit is 0; at most one in_ready bit is high per cycle.
REQ-019 Transfer in = in_valid[g] & in_ready[g]; on the next edge out_data <= in_data[g], out_ch <= g, out_valid <= 1.
REQ-020 Latency is exactly 1 clk from input transfer to out_valid.
REQ-021 When load is high and no input transfer occurs, out_valid <= 0 at the next edge; out_data and out_ch hold their previous values.
REQ-022 While out_valid & !out_ready, out_valid, out_data and out_ch are held stable and all in_ready bits are 0.
REQ-023 Simultaneous output drain and input transfer in the same cycle gives back-to-back words with no bubble; full throughput is 1 word/clk.
REQ-024 rr_ptr (SELW bits) updates only on an input transfer, to (g+1) mod CHANNELS, in both modes; it holds otherwise.
REQ-025 A mode change takes effect in the same cycle's arbitration; rr_ptr is not reset by a mode change.
REQ-026 CHANNELS == 1: g is always 0, out_ch is always 0 and rr_ptr stays 0; the block behaves as a 1-deep registered pipe.
REQ-027 in_data of non-granted channels has no effect on any state.

Reset
REQ-028 With reset high at an edge: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = 0.
REQ-029 reset has priority over any transfer in the same cycle; a word held in the output register is discarded and never presented.
REQ-030 in_ready is all 0 in any cycle where reset is high.

Verification (WIDTH=8, CHANNELS=4)
REQ-031 Apply reset, then idle -> out_valid=0, out_data=0x00, out_ch=0, in_ready=0000.
REQ-032 mode=0; in_valid=1010; data ch1=0x11, ch3=0x33; out_ready=1 for 3 clks -> out_ch sequence 1,1,1; ch3 never granted (starvation accepted in fixed mode).
REQ-033 mode=1; in_valid=1111 held; out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive clks with no bubbles.
REQ-034 mode=1; word ch2=0xA5 registered; out_ready=0 for 3 clks with in_valid=0001 -> out_data stays 0xA5, out_ch stays 2, in_ready=0000; out_ready=1 -> ch0 word appears on the next clk.
REQ-035 Mid-stream reset with out_valid=1 and rr_ptr=3 -> next clk: out_valid=0, rr_ptr=0; with mode=1 and in_valid=1001 the first grant is ch0.
REQ-036 Sweep all 16 in_valid patterns in both modes -> at most one in_ready bit high per cycle, and that bit matches the REQ-016/REQ-017 grant.
